// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing stream path.
// Provides the default frame geometry, the line-credit counter width,
// the feeder FSM state type and a small width helper.
package img_proc_pkg;

    localparam int unsigned DEF_IMG_WIDTH     = 512;
    localparam int unsigned DEF_IMG_HEIGHT    = 512;
    localparam int unsigned DEF_PREFILL_LINES = 4;
    localparam int unsigned DEF_PAD_LINES     = 2;
    localparam int unsigned DEF_ADDR_W        = 18;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CREDIT_W = 4;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_e;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/img_line_feeder_feed_skid_fifo.sv
// feed_skid_fifo: 2-entry, 8-bit skid buffer between the frame-buffer read
// pipe and the processor stream interface.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears contents)
//   in_valid/in_data   write side; a write while full is dropped, the
//                      producer uses count to guarantee room
//   out_valid/out_data/out_ready  read side, transfer on valid && ready
//   count           current occupancy 0..2
module feed_skid_fifo
    import img_proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push_c, pop_c;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_c   = in_valid && (count_q != 2'd2);
        pop_c    = out_valid && out_ready;
        if (push_c) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push_c) - 2'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/img_line_feeder.sv
// img_line_feeder: reads an 8-bit grayscale frame from a byte-addressed
// frame-buffer read port and streams it to the processor, paced by line
// credits: PREFILL_LINES lines after start, then one line per rising edge
// of i_intr.
// Build option: IMG_LINE_FEEDER_PAD_EN -- when defined, PAD_LINES zero
// lines follow the image; otherwise the frame ends after IMG_HEIGHT lines.
// Ports:
//   axi_clk, axi_reset     clock, synchronous active-high reset
//   i_start                start pulse (ignored while busy)
//   o_busy, o_done         frame in progress / one-cycle completion pulse
//   o_mem_rd_en, o_mem_addr, i_mem_rd_data   frame-buffer read, 1-cycle data
//   o_data_valid, o_data, i_data_ready       processor stream
//   i_intr                 line-consumed interrupt (rising-edge detected)
module img_line_feeder
    import img_proc_pkg::*;
#(
    parameter int unsigned IMG_WIDTH     = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT    = DEF_IMG_HEIGHT,
    parameter int unsigned PREFILL_LINES = DEF_PREFILL_LINES,
    parameter int unsigned PAD_LINES     = DEF_PAD_LINES,
    parameter int unsigned ADDR_W        = DEF_ADDR_W
) (
    input  logic              axi_clk,
    input  logic              axi_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_data_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_data_ready,
    input  logic              i_intr
);

`ifdef IMG_LINE_FEEDER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int unsigned TOTAL_LINES = IMG_HEIGHT + (PAD_EN ? PAD_LINES : 0);
    localparam int unsigned PIX_W       = clog2_min1(IMG_WIDTH);
    localparam int unsigned LINE_W      = clog2_min1(TOTAL_LINES + 1);
    localparam int unsigned CREDIT_LIM  = (1 << CREDIT_W) - 1;
    localparam logic [CREDIT_W-1:0] PREFILL_CREDITS =
        CREDIT_W'((PREFILL_LINES > CREDIT_LIM) ? CREDIT_LIM : PREFILL_LINES);

    feed_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                inflight_q, inflight_d;
    logic                intr_s_q, intr_s_d;
    logic                intr_p_q, intr_p_d;

    logic                intr_rise_c;
    logic                pop_c;
    logic [1:0]          occ_c;
    logic                room_c;
    logic                issue_c;
    logic                line_end_c;
    logic                frame_end_c;

    logic                fifo_valid;
    logic [DATA_W-1:0]   fifo_data;
    logic [1:0]          fifo_count;
    logic [DATA_W-1:0]   fifo_in_data;

    // Room check: bytes already buffered plus the read returning this cycle,
    // minus a byte leaving now, must leave a slot for a read issued now.
    assign pop_c       = fifo_valid && i_data_ready;
    assign occ_c       = fifo_count + {1'b0, inflight_q};
    assign room_c      = (occ_c - {1'b0, pop_c}) <= 2'd1;
    assign issue_c     = (state_q == ST_FEED) && (credits_q != '0) && room_c;
    assign line_end_c  = issue_c && (pix_q == PIX_W'(IMG_WIDTH - 1));
    assign frame_end_c = line_end_c && (line_q == LINE_W'(TOTAL_LINES - 1));
    assign intr_rise_c = intr_s_q && !intr_p_q;

`ifdef IMG_LINE_FEEDER_PAD_EN
    logic inflight_pad_q, inflight_pad_d;
    logic in_image_c;

    // Pad lines skip the memory read; a zero rides the same 1-cycle pipe.
    assign in_image_c   = line_q < LINE_W'(IMG_HEIGHT);
    assign o_mem_rd_en  = issue_c && in_image_c;
    assign fifo_in_data = inflight_pad_q ? '0 : i_mem_rd_data;

    always_comb begin
        inflight_pad_d = issue_c && !in_image_c;
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            inflight_pad_q <= 1'b0;
        end else begin
            inflight_pad_q <= inflight_pad_d;
        end
    end
`else
    assign o_mem_rd_en  = issue_c;
    assign fifo_in_data = i_mem_rd_data;
`endif

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_mem_addr   = addr_q;
    assign o_data_valid = fifo_valid;
    assign o_data       = fifo_data;

    // Next-state: FSM, line credits and pixel/line/address counters.
    always_comb begin
        state_d    = state_q;
        credits_d  = credits_q;
        pix_d      = pix_q;
        line_d     = line_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inflight_d = issue_c;
        intr_s_d   = i_intr;
        intr_p_d   = intr_s_q;

        // Interrupt adds a line credit, line completion spends one.
        if (state_q != ST_IDLE) begin
            if (intr_rise_c && !line_end_c) begin
                if (credits_q != CREDIT_MAX) begin
                    credits_d = credits_q + CREDIT_W'(1);
                end
            end else if (!intr_rise_c && line_end_c) begin
                credits_d = credits_q - CREDIT_W'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d   = ST_FEED;
                    busy_d    = 1'b1;
                    credits_d = PREFILL_CREDITS;
                    pix_d     = '0;
                    line_d    = '0;
                    addr_d    = '0;
                end
            end
            ST_FEED: begin
                if (issue_c) begin
                    if (o_mem_rd_en) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    if (line_end_c) begin
                        pix_d  = '0;
                        line_d = line_q + LINE_W'(1);
                        if (frame_end_c) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if ((fifo_count == 2'd0) && !inflight_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state_q    <= ST_IDLE;
            credits_q  <= '0;
            pix_q      <= '0;
            line_q     <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            intr_s_q   <= 1'b0;
            intr_p_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            intr_s_q   <= intr_s_d;
            intr_p_q   <= intr_p_d;
        end
    end

    feed_skid_fifo u_skid (
        .clk       (axi_clk),
        .rst       (axi_reset),
        .in_valid  (inflight_q),
        .in_data   (fifo_in_data),
        .out_valid (fifo_valid),
        .out_data  (fifo_data),
        .out_ready (i_data_ready),
        .count     (fifo_count)
    );

endmodule

// File: doc/img_line_feeder.md
# img_line_feeder

Hardware stream source for the image processing core. Reads an 8-bit grayscale frame from a byte-addressed frame-buffer read port and drives it onto the core's `i_data_valid`/`i_data` slave interface. Pacing follows the core's line-buffer protocol: an initial prefill of several lines, then one line per interrupt pulse, then zero-padded lines to flush the filter window. Replaces the software/bench-side feeder so the full filter path runs from on-chip memory.

## Interface
- `IMG_WIDTH`, 512, pixels per line
- `IMG_HEIGHT`, 512, lines per frame
- `PREFILL_LINES`, 4, lines sent after start without waiting for an interrupt
- `PAD_LINES`, 2, zero lines appended after the last image line
- `ADDR_W`, 18, frame-buffer address width (≥ clog2(IMG_WIDTH*IMG_HEIGHT))
- `axi_clk`  in  1  clock
- `axi_reset`  in  1  reset; synchronous, active-high
- `i_start`  in  1  one-cycle pulse; starts a frame (ignored while `o_busy`)
- `o_busy`  out  1  high from accepted start until `o_done`
- `o_done`  out  1  one-cycle pulse after the last byte is accepted
- `o_mem_rd_en`  out  1  frame-buffer read strobe
- `o_mem_addr`  out  ADDR_W  byte address, valid with `o_mem_rd_en`
- `i_mem_rd_data`  in  8  read data, exactly 1 cycle after `o_mem_rd_en`
- `o_data_valid`  out  1  stream byte valid, to processor `i_data_valid`
- `o_data`  out  8  stream byte
- `i_data_ready`  in  1  processor ready; transfer on `o_data_valid && i_data_ready`
- `i_intr`  in  1  processor interrupt (line consumed); level, rising-edge detected

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: outputs quiet; `i_start` -> FEED; credits := PREFILL_LINES, line := 0, pix := 0, addr := 0.
- Credit counter (4 bits, saturate at 15): +1 on each registered rising edge of `i_intr`; −1 when the last pixel of a line is issued. Simultaneous +1/−1 -> unchanged. `i_intr` edges in IDLE are ignored.
- FEED: while credits > 0 and skid buffer has room (counting the in-flight read), issue one pixel per cycle. Image lines (line < IMG_HEIGHT): `o_mem_rd_en`=1, addr increments linearly 0..W*H−1. Pad lines: no memory read; a zero byte enters the same 1-cycle pipe.
- pix wraps IMG_WIDTH−1 -> 0 and increments line; no bubble between lines when credits remain.
- After the last pixel of the last line is issued -> DRAIN; when skid buffer empty and no read in flight -> DONE; DONE pulses `o_done`, clears `o_busy`, -> IDLE.
- Stream: `o_data_valid` = skid buffer non-empty; `o_data` = head; both stable while stalled by `i_data_ready`=0. No byte dropped or duplicated.
- Reset at any time: state IDLE, counters and skid buffer cleared, in-flight read data discarded.

## Timing
- Reset values: `o_busy`, `o_done`, `o_mem_rd_en`, `o_data_valid` = 0; `o_mem_addr`, `o_data` = 0.
- `i_start` sampled at edge N: `o_busy` and first `o_mem_rd_en` (addr 0) in cycle N+1; byte in buffer at edge ending N+2; `o_data_valid` high in N+3.
- Steady throughput 1 byte/cycle with `i_data_ready` held high and credits available.
- `i_intr` rising edge at edge M: credit usable from cycle M+2.
- Skid buffer depth 2: absorbs the read issued in the cycle `i_data_ready` falls.

## Configuration
- `IMG_LINE_FEEDER_PAD_EN`: defined -> PAD_LINES zero lines follow the image, frame total (IMG_HEIGHT+PAD_LINES)*IMG_WIDTH bytes. Undefined -> no pad logic; frame ends after IMG_HEIGHT lines, PAD_LINES ignored.

## Structure
- Shared package `img_proc_pkg`: state enum, default geometry constants (512, 512, 4, 2), credit width.
- One sub-module: `feed_skid_fifo` (2-entry, 8-bit, valid/ready, synchronous reset).

## Test plan
- Reset: hold `axi_reset` 3 cycles mid-stream -> all outputs 0 next cycle; `i_start` afterwards restarts at addr 0.
- Prefill: memory = addr mod 256, ready=1, no intr -> exactly 2048 bytes (0..255 repeating), then `o_data_valid` low indefinitely.
- One `i_intr` pulse after prefill -> exactly 512 bytes, first value 0 (addr 2048), addresses 2048..2559.
- Backpressure: `i_data_ready` toggling every cycle and random 0–5 cycle stalls -> byte sequence identical to unstalled run, `o_data` stable while stalled.
- Credits: two `i_intr` pulses during one line, one coincident with line end -> exactly two further back-to-back lines, no gap.
- Full frame, intr after each line: 262144 image bytes + 1024 zeros, single `o_done` pulse, `o_busy` low after; macro undefined -> 262144 bytes then `o_done`.
